// File: rtl/smi_rx_arbiter.sv
// Round-robin scheduler between the 0.9 GHz and 2.4 GHz sample FIFOs. Words are
// pulled one at a time and serialized MSB-first onto a byte stream for the SMI read engine.
module smi_rx_arbiter #(
   parameter int BURST_WORDS = 16
) (
   input  logic        i_sys_clk,
   input  logic        i_reset,
   input  logic        i_enable_09,
   input  logic        i_enable_24,
   output logic        o_fifo_09_pull,
   output logic        o_fifo_24_pull,
   input  logic [31:0] i_fifo_09_pulled_data,
   input  logic [31:0] i_fifo_24_pulled_data,
   input  logic        i_fifo_09_empty,
   input  logic        i_fifo_24_empty,
   output logic [7:0]  o_byte,
   output logic        o_byte_valid,
   input  logic        i_byte_ready,
   output logic        o_byte_ch,
   output logic        o_byte_sof,
   output logic        o_busy,
   output logic        o_read_req
);

   localparam logic [7:0] BURST_MAX = BURST_WORDS[7:0];

   typedef enum logic [1:0] {ARB, PULL, LATCH, SEND} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        rr;
   logic        ch;
   logic        first;
   logic [7:0]  wcnt;
   logic [1:0]  bidx;
   logic [31:0] sr;

   logic        elig_09;
   logic        elig_24;
   logic        grant;
   logic        grant_ch;
   logic        ch_enabled;
   logic        ch_empty;
   logic        handshake;
   logic        word_end;
   logic        more_words;

   assign elig_09    = i_enable_09 & ~i_fifo_09_empty;
   assign elig_24    = i_enable_24 & ~i_fifo_24_empty;
   assign o_read_req = elig_09 | elig_24;
   assign grant      = elig_09 | elig_24;
   // The preferred channel wins when eligible; otherwise whichever one is.
   assign grant_ch   = rr ? elig_24 : ~elig_09;

   assign ch_enabled = ch ? i_enable_24 : i_enable_09;
   assign ch_empty   = ch ? i_fifo_24_empty : i_fifo_09_empty;
   assign handshake  = (state == SEND) & i_byte_ready;
   assign word_end   = handshake & (bidx == 2'd0);
   assign more_words = (wcnt < BURST_MAX) & ch_enabled & ~ch_empty;

   always_ff @(posedge i_sys_clk) begin
      if (i_reset)
         state <= ARB;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      o_fifo_09_pull = 1'b0;
      o_fifo_24_pull = 1'b0;
      o_byte_valid   = 1'b0;
      o_byte         = 8'h00;
      o_byte_ch      = 1'b0;
      o_byte_sof     = 1'b0;
      o_busy         = (state != ARB);
      case (state)
         ARB: begin
            if (grant)
               state_nxt = PULL;
         end
         PULL: begin
            o_fifo_09_pull = ~ch;
            o_fifo_24_pull = ch;
            state_nxt      = LATCH;
         end
         LATCH: begin
            state_nxt = SEND;
         end
         SEND: begin
            o_byte_valid = 1'b1;
            o_byte       = sr[{bidx, 3'b000} +: 8];
            o_byte_ch    = ch;
            o_byte_sof   = first & (bidx == 2'd3);
            if (word_end)
               state_nxt = more_words ? PULL : ARB;
         end
         default: state_nxt = ARB;
      endcase
   end

   // Burst bookkeeping; a reset drops any partially sent word.
   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         rr    <= 1'b0;
         ch    <= 1'b0;
         first <= 1'b0;
         wcnt  <= 8'd0;
         bidx  <= 2'd0;
      end else begin
         case (state)
            ARB: begin
               if (grant) begin
                  ch    <= grant_ch;
                  wcnt  <= 8'd0;
                  first <= 1'b1;
               end
            end
            LATCH: begin
               bidx <= 2'd3;
               wcnt <= wcnt + 8'd1;
            end
            SEND: begin
               if (handshake) begin
                  if (bidx == 2'd3)
                     first <= 1'b0;
                  if (bidx != 2'd0)
                     bidx <= bidx - 2'd1;
                  else if (!more_words)
                     rr <= ~ch;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_sys_clk) begin
      if (state == LATCH)
         sr <= ch ? i_fifo_24_pulled_data : i_fifo_09_pulled_data;
   end

endmodule
